// File: rtl/sparse_feature_encoder_if.sv
// Handshake and list bus between the dense feature-map buffer and the PE sparse list consumer.
// master = encoder side, slave = buffer/PE side. SPARSE_ENC_THRESH_EN adds the thresh input.
interface sparse_feature_encoder_if #(
  parameter int word_length        = 8,
  parameter int col_length         = 8,
  parameter int double_word_length = 16,
  parameter int max_nnz            = 52
);
  logic                               start;
  logic                               pix_valid;
  logic                               pix_ready;
  logic [word_length-1:0]             pix_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [double_word_length-1:0]      feature_valid_num;
  logic [max_nnz*word_length-1:0]     feature_value;
  logic [max_nnz*col_length-1:0]      feature_cols;
  logic [max_nnz*col_length-1:0]      feature_rows;
  logic                               overflow;
`ifdef SPARSE_ENC_THRESH_EN
  logic [word_length-1:0]             thresh;
`endif

  modport master (
`ifdef SPARSE_ENC_THRESH_EN
    input  thresh,
`endif
    input  start, pix_valid, pix_data, out_ready,
    output pix_ready, out_valid, feature_valid_num, feature_value,
           feature_cols, feature_rows, overflow
  );

  modport slave (
`ifdef SPARSE_ENC_THRESH_EN
    output thresh,
`endif
    output start, pix_valid, pix_data, out_ready,
    input  pix_ready, out_valid, feature_valid_num, feature_value,
           feature_cols, feature_rows, overflow
  );
endinterface

// File: rtl/sparse_feature_encoder.sv
// Dense row-major feature map -> packed nonzero (value,col,row) list, held until the PE accepts it.
// SPARSE_ENC_THRESH_EN: pixels with |pix_data| <= thresh (sampled on start) are treated as zero.
module sparse_feature_encoder #(
  parameter int word_length        = 8,
  parameter int col_length         = 8,
  parameter int double_word_length = 16,
  parameter int image_size         = 7,
  parameter int max_nnz            = 52
) (
  input logic                  clk,
  input logic                  rst,
  sparse_feature_encoder_if.master bus
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  localparam logic [col_length-1:0]         LAST = col_length'(image_size - 1);
  localparam logic [double_word_length-1:0] CAP  = double_word_length'(max_nnz);

  state_t                         state_q, state_d;
  logic [col_length-1:0]          row_q, row_d, col_q, col_d;
  logic [double_word_length-1:0]  cnt_q, cnt_d;
  logic [max_nnz*word_length-1:0] val_q, val_d;
  logic [max_nnz*col_length-1:0]  cols_q, cols_d, rows_q, rows_d;
  logic                           ovf_q, ovf_d;
  logic                           xfer, nz;

`ifdef SPARSE_ENC_THRESH_EN
  logic [word_length-1:0] thresh_q, thresh_d, mag;
  // -128 negates to 0x80, which read unsigned is the required 128
  assign mag = bus.pix_data[word_length-1] ? (-bus.pix_data) : bus.pix_data;
  assign nz  = (mag > thresh_q);
`else
  assign nz  = (bus.pix_data != '0);
`endif

  assign xfer = bus.pix_valid && (state_q == FILL);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    cols_d  = cols_q;
    rows_d  = rows_q;
    ovf_d   = ovf_q;
`ifdef SPARSE_ENC_THRESH_EN
    thresh_d = thresh_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = FILL;
        row_d   = '0;
        col_d   = '0;
        cnt_d   = '0;
        val_d   = '0;
        cols_d  = '0;
        rows_d  = '0;
        ovf_d   = 1'b0;
`ifdef SPARSE_ENC_THRESH_EN
        thresh_d = bus.thresh;
`endif
      end
      FILL: if (xfer) begin
        if (nz) begin
          if (cnt_q < CAP) begin
            for (int k = 0; k < max_nnz; k++) begin
              if (cnt_q == double_word_length'(k)) begin
                val_d[k*word_length +: word_length] = bus.pix_data;
                cols_d[k*col_length +: col_length]  = col_q;
                rows_d[k*col_length +: col_length]  = row_q;
              end
            end
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (col_q == LAST) begin
          col_d = '0;
          if (row_q == LAST) begin
            row_d   = '0;
            state_d = HOLD;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      HOLD: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      val_q    <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      ovf_q    <= 1'b0;
`ifdef SPARSE_ENC_THRESH_EN
      thresh_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      cols_q   <= cols_d;
      rows_q   <= rows_d;
      ovf_q    <= ovf_d;
`ifdef SPARSE_ENC_THRESH_EN
      thresh_q <= thresh_d;
`endif
    end
  end

  // all outputs decode straight from flops; the list is frozen outside FILL
  assign bus.pix_ready         = (state_q == FILL);
  assign bus.out_valid         = (state_q == HOLD);
  assign bus.feature_valid_num = cnt_q;
  assign bus.feature_value     = val_q;
  assign bus.feature_cols      = cols_q;
  assign bus.feature_rows      = rows_q;
  assign bus.overflow          = ovf_q;
endmodule

// File: tb/tb_sparse_feature_encoder.sv
// Scoreboard bench: two encoders (capacity 52 and 40) share one random pixel stream.
module tb_sparse_feature_encoder;
  localparam int WL = 8, CL = 8, DWL = 16, N = 7, NP = 49, CAP_A = 52, CAP_B = 40;
  localparam int BW = CAP_A * WL;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, pix_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] pix_data = '0;
`ifdef SPARSE_ENC_THRESH_EN
  logic [7:0] thresh = '0;
`endif

  sparse_feature_encoder_if #(.word_length(WL), .col_length(CL), .double_word_length(DWL), .max_nnz(CAP_A)) bus_a ();
  sparse_feature_encoder_if #(.word_length(WL), .col_length(CL), .double_word_length(DWL), .max_nnz(CAP_B)) bus_b ();

  assign bus_a.start = start;     assign bus_b.start = start;
  assign bus_a.pix_valid = pix_valid; assign bus_b.pix_valid = pix_valid;
  assign bus_a.pix_data = pix_data;   assign bus_b.pix_data = pix_data;
  assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready;
`ifdef SPARSE_ENC_THRESH_EN
  assign bus_a.thresh = thresh;   assign bus_b.thresh = thresh;
`endif

  sparse_feature_encoder #(.word_length(WL), .col_length(CL), .double_word_length(DWL), .image_size(N), .max_nnz(CAP_A))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  sparse_feature_encoder #(.word_length(WL), .col_length(CL), .double_word_length(DWL), .image_size(N), .max_nnz(CAP_B))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic [15:0]   cnt;
    logic          ovf;
    logic [BW-1:0] v, c, r;
  } frame_t;

  frame_t qa[$], qb[$];
  frame_t snap[2];
  bit     have_snap[2];
  int     n_checks = 0, n_fail = 0;
  logic [7:0] p[NP];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pixel kept in the list? (magnitude compare, |-128| = 128)
  function automatic bit keep(input logic [7:0] px, input int thr);
    int s;
    s = int'($signed(px));
    if (s < 0) s = -s;
`ifdef SPARSE_ENC_THRESH_EN
    return s > thr;
`else
    return (s != 0) && (thr >= 0);
`endif
  endfunction

  function automatic frame_t model(input logic [7:0] pix[NP], input int cap, input int thr);
    frame_t f;
    int n;
    f.cnt = '0; f.ovf = 1'b0; f.v = '0; f.c = '0; f.r = '0;
    n = 0;
    for (int k = 0; k < NP; k++) begin
      if (keep(pix[k], thr)) begin
        if (n < cap) begin
          f.v[n*8 +: 8] = pix[k];
          f.c[n*8 +: 8] = 8'(k % N);
          f.r[n*8 +: 8] = 8'(k / N);
          n++;
        end else begin
          f.ovf = 1'b1;
        end
      end
    end
    f.cnt = 16'(n);
    return f;
  endfunction

  task automatic mon(input int w, input logic ov, input logic ordy, input logic prdy, input logic [15:0] cnt,
                     input logic ovf, input logic [BW-1:0] v, input logic [BW-1:0] c, input logic [BW-1:0] r);
    frame_t e;
    if (!ov) begin
      have_snap[w] = 1'b0;
      return;
    end
    if (!have_snap[w]) begin
      snap[w].cnt = cnt; snap[w].ovf = ovf; snap[w].v = v; snap[w].c = c; snap[w].r = r;
      have_snap[w] = 1'b1;
    end else begin
      chk($sformatf("hold_stable[%0d]", w),
          BW'(cnt == snap[w].cnt && ovf == snap[w].ovf && v == snap[w].v && c == snap[w].c && r == snap[w].r), BW'(1));
    end
    chk($sformatf("pix_ready_in_hold[%0d]", w), BW'(prdy), BW'(0));
    if (ordy) begin
      if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_frame[%0d]: got count %0d expected no frame", w, cnt);
      end else begin
        if (w == 0) e = qa.pop_front(); else e = qb.pop_front();
        chk($sformatf("count[%0d]", w),    BW'(cnt), BW'(e.cnt));
        chk($sformatf("overflow[%0d]", w), BW'(ovf), BW'(e.ovf));
        chk($sformatf("values[%0d]", w),   v, e.v);
        chk($sformatf("cols[%0d]", w),     c, e.c);
        chk($sformatf("rows[%0d]", w),     r, e.r);
      end
    end
  endtask

  always @(negedge clk) if (rst) begin
    mon(0, bus_a.out_valid, out_ready, bus_a.pix_ready, bus_a.feature_valid_num, bus_a.overflow,
        bus_a.feature_value, bus_a.feature_cols, bus_a.feature_rows);
    mon(1, bus_b.out_valid, out_ready, bus_b.pix_ready, bus_b.feature_valid_num, bus_b.overflow,
        BW'(bus_b.feature_value), BW'(bus_b.feature_cols), BW'(bus_b.feature_rows));
  end

  task automatic check_zero(input string tag);
    chk({tag, "_pix_ready"}, BW'(bus_a.pix_ready), BW'(0));
    chk({tag, "_out_valid"}, BW'(bus_a.out_valid | bus_b.out_valid), BW'(0));
    chk({tag, "_count"},     BW'(bus_a.feature_valid_num | bus_b.feature_valid_num), BW'(0));
    chk({tag, "_overflow"},  BW'(bus_a.overflow | bus_b.overflow), BW'(0));
    chk({tag, "_buses"},     bus_a.feature_value | bus_a.feature_cols | bus_a.feature_rows, BW'(0));
  endtask

  task automatic send_frame(input int gap_pct, input int hold);
    frame_t ea;
    int idx, guard, thr;
`ifdef SPARSE_ENC_THRESH_EN
    logic [7:0] saved;
    thr = int'(thresh);
    saved = thresh;
`else
    thr = 0;
`endif
    ea = model(p, CAP_A, thr);
    qa.push_back(ea);
    qb.push_back(model(p, CAP_B, thr));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
`ifdef SPARSE_ENC_THRESH_EN
    thresh = 8'($urandom);
`endif
    chk("pix_ready_fill", BW'(bus_a.pix_ready), BW'(1));
    idx = 0; guard = 0;
    while (idx < NP && guard < 2000) begin
      pix_valid = (int'($urandom_range(0, 99)) >= gap_pct);
      pix_data  = pix_valid ? p[idx] : 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (pix_valid) idx++;
      #1 guard++;
    end
    if (guard >= 2000) begin
      n_checks++; n_fail++;
      $display("FAIL fill_timeout: got %0d pixels required %0d", idx, NP);
    end
    pix_valid = 1'b0; out_ready = 1'b0; pix_data = '0;
    chk("out_valid_rise", BW'(bus_a.out_valid & bus_b.out_valid), BW'(1));
    repeat (hold) begin
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("idle_out_valid", BW'(bus_a.out_valid | bus_b.out_valid), BW'(0));
    chk("idle_pix_ready", BW'(bus_a.pix_ready), BW'(0));
    chk("idle_list_kept", BW'(bus_a.feature_valid_num), BW'(ea.cnt));
`ifdef SPARSE_ENC_THRESH_EN
    thresh = saved;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b1;

    // partial frame aborted by reset after 10 pixels
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pix_data = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_zero("mid_reset");
    @(posedge clk); #1 check_zero("mid_reset_next");
    rst = 1'b1;

    foreach (p[i]) p[i] = '0;
    send_frame(0, 0);

    p[0] = 8'h1a; p[1] = 8'hfc; p[48] = 8'hf4;
    send_frame(20, 3);

    foreach (p[i]) p[i] = 8'($urandom_range(1, 255));
    send_frame(40, 1);

    foreach (p[i]) p[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    send_frame(10, 20);

    for (int f = 0; f < 4; f++) begin
      int dens;
      dens = int'($urandom_range(0, 100));
      foreach (p[i]) p[i] = (int'($urandom_range(0, 99)) < dens) ? 8'($urandom) : 8'h00;
      send_frame(int'($urandom_range(0, 50)), int'($urandom_range(0, 5)));
    end

`ifdef SPARSE_ENC_THRESH_EN
    foreach (p[i]) p[i] = '0;
    p[0] = 8'h03; p[1] = 8'hfd; p[2] = 8'h05; p[3] = 8'h80;
    thresh = 8'd4;
    send_frame(0, 0);
    thresh = '0;
`endif

    repeat (3) @(posedge clk);
    #1 chk("queues_drained", BW'(qa.size() + qb.size()), BW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
